// File: rtl/debounce_scheduler.sv
// Purpose : one shared debounce timer for NUM_BTN raw buttons. A round-robin
//           arbiter grants the timer to one pressed button, and an FSM
//           qualifies the press and the release against DEBOUNCE_CYCLES.
// Latency : a raw rise sampled at edge k is granted at edge k+2. btn_pulse is
//           high in the cycle after edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none. Buttons that are not granted simply wait while busy and
//           are arbitrated again when the FSM returns to IDLE.
// Ports   : clock      - system clock, rising edge
//           reset      - asynchronous, active-high, clears all state
//           btn_raw    - raw asynchronous button levels (1 = pressed)
//           btn_pulse  - one-hot, one-cycle pulse per accepted press
//           btn_level  - one-hot debounced level of the granted button
//           busy       - high in any state other than IDLE
//           active_idx - index of the granted button, valid while busy
// Option  : define AUTO_REPEAT_EN to re-pulse every REPEAT_CYCLES while held.
module debounce_scheduler #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 30000000,
  parameter int CNT_W           = 26,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               busy,
  output logic [2:0]         active_idx
);

  if (NUM_BTN < 2 || NUM_BTN > 8 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      $clog2(DEBOUNCE_CYCLES) > CNT_W || $clog2(REPEAT_CYCLES) > CNT_W) begin : g_bad_params
    $error("debounce_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    SETTLE_PRESS   = 2'd1,
    HELD           = 2'd2,
    SETTLE_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t             state, state_nx;
  logic [NUM_BTN-1:0] sync_meta, sync;
  logic [2:0]         idx_nx;
  logic [2:0]         rr_ptr, rr_nx;
  logic [CNT_W-1:0]   timer, timer_nx;
  logic [NUM_BTN-1:0] pulse, pulse_nx;

  logic [7:0]         sync_ext;
  logic               idx_sync;
  logic [2:0]         idx_inc;
  logic [NUM_BTN-1:0] idx_onehot;
  logic [3:0]         cand;
  logic               grant_vld;
  logic [2:0]         grant_idx;

  // Two-flop synchronizer; everything downstream looks at sync only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Zero-extend to 8 bits so a 3-bit index selects exactly.
  assign sync_ext   = 8'(sync);
  assign idx_sync   = sync_ext[active_idx];
  assign idx_inc    = (active_idx == 3'(NUM_BTN - 1)) ? 3'd0 : active_idx + 3'd1;
  assign idx_onehot = NUM_BTN'(1) << active_idx;

  // Round-robin: first pressed button at or after rr_ptr, wrapping at NUM_BTN.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    cand      = 4'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(NUM_BTN)) cand = cand - 4'(NUM_BTN);
      if (!grant_vld && sync_ext[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = active_idx;
    rr_nx    = rr_ptr;
    timer_nx = timer;
    pulse_nx = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          idx_nx   = grant_idx;
          timer_nx = '0;
          state_nx = SETTLE_PRESS;
        end
      end
      SETTLE_PRESS: begin
        // A drop at any point, including the terminal cycle, rejects the press.
        if (!idx_sync) begin
          rr_nx    = idx_inc;
          timer_nx = '0;
          state_nx = IDLE;
        end else if (timer == DEB_TC) begin
          timer_nx = '0;
          pulse_nx = idx_onehot;
          state_nx = HELD;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      HELD: begin
        // Release takes priority over a repeat pulse in the same cycle.
        if (!idx_sync) begin
          timer_nx = '0;
          state_nx = SETTLE_RELEASE;
        end
`ifdef AUTO_REPEAT_EN
        else if (timer == REP_TC) begin
          timer_nx = '0;
          pulse_nx = idx_onehot;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
`endif
      end
      SETTLE_RELEASE: begin
        if (idx_sync) begin
          timer_nx = '0;
          state_nx = HELD;
        end else if (timer == DEB_TC) begin
          timer_nx = '0;
          rr_nx    = idx_inc;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      active_idx <= 3'd0;
      rr_ptr     <= 3'd0;
      timer      <= '0;
      pulse      <= '0;
    end else begin
      state      <= state_nx;
      active_idx <= idx_nx;
      rr_ptr     <= rr_nx;
      timer      <= timer_nx;
      pulse      <= pulse_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign btn_level = (state == HELD || state == SETTLE_RELEASE) ? idx_onehot : '0;
  assign btn_pulse = pulse;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Purpose : stimulus and checking for debounce_scheduler with short timings.
// Ports   : none (top-level bench).
module tb_debounce_scheduler;
  localparam int NB   = 4;
  localparam int D    = 8;
  localparam int R    = 16;
  localparam int CW   = 5;
  localparam int MAXN = 700;
`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_pulse, btn_level;
  logic          busy;
  logic [2:0]    active_idx;

  debounce_scheduler #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .REPEAT_CYCLES(R)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .btn_pulse(btn_pulse),
    .btn_level(btn_level), .busy(busy), .active_idx(active_idx));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // raw_tr[n] is the value sampled at edge n; o_*/e_*[n] are outputs after edge n.
  logic [NB-1:0] raw_tr  [0:MAXN];
  logic [NB-1:0] o_pulse [0:MAXN];
  logic [NB-1:0] o_level [0:MAXN];
  logic          o_busy  [0:MAXN];
  logic [2:0]    o_idx   [0:MAXN];
  logic [NB-1:0] e_pulse [0:MAXN];
  logic [NB-1:0] e_level [0:MAXN];
  logic          e_busy  [0:MAXN];
  logic [2:0]    e_idx   [0:MAXN];

  task automatic clear_trace();
    for (int i = 0; i <= MAXN; i++) raw_tr[i] = '0;
  endtask

  task automatic set_range(input int lo, input int hi, input logic [NB-1:0] v);
    for (int i = lo; i <= hi; i++) raw_tr[i] = v;
  endtask

  task automatic run_trace(input int n);
    @(negedge clock);
    reset   = 1'b1;
    btn_raw = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= n; i++) begin
      btn_raw = raw_tr[i];
      @(posedge clock);
      #1;
      o_pulse[i] = btn_pulse;
      o_level[i] = btn_level;
      o_busy[i]  = busy;
      o_idx[i]   = active_idx;
      if (i < n) @(negedge clock);
    end
  endtask

  // Synchronized view at edge n is the raw value sampled two edges earlier.
  function automatic logic [NB-1:0] svec(input int n);
    if (n - 2 < 1 || n - 2 > MAXN) return '0;
    return raw_tr[n-2];
  endfunction

  function automatic bit sbit(input int n, input int b);
    logic [NB-1:0] v;
    v = svec(n);
    return v[b];
  endfunction

  function automatic int count_pulses(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (o_pulse[i] != '0) c++;
    return c;
  endfunction

  function automatic int first_pulse(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (o_pulse[i] != '0) return i;
    return -1;
  endfunction

  function automatic int multi_pulses(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if ($countones(o_pulse[i]) > 1) c++;
    return c;
  endfunction

  // Reference: walk the synchronized trace press by press. A grant at edge g is
  // accepted if the button stays high for the next D edges; a release starting
  // at edge e completes if it stays low for D edges, else HELD resumes.
  task automatic build_model(input int n);
    int t, g, idx, m, h, e, ptr, lvl_from;
    bit done;
    logic [NB-1:0] s, oh;
    for (int i = 0; i <= MAXN; i++) begin
      e_pulse[i] = '0; e_level[i] = '0; e_busy[i] = 1'b0; e_idx[i] = 3'd0;
    end
    ptr = 0;
    t   = 1;
    while (t <= n) begin
      s = svec(t);
      if (s == '0) begin
        t++;
      end else begin
        idx = -1;
        for (int i = 0; i < NB; i++) if (idx < 0 && s[(ptr + i) % NB]) idx = (ptr + i) % NB;
        oh = '0;
        oh[idx] = 1'b1;
        g = t;
        m = 1;
        while (m <= D && sbit(g + m, idx)) m++;
        if (m <= D) begin
          for (int i = g; i < g + m && i <= n; i++) begin e_busy[i] = 1'b1; e_idx[i] = 3'(idx); end
          t = g + m + 1;
        end else begin
          h = g + D;
          lvl_from = h;
          if (h <= n) e_pulse[h] = oh;
          done = 1'b0;
          e = h;
          while (!done) begin
            e = h + 1;
            while (sbit(e, idx)) e++;
            if (REP) for (int p = h + R; p < e; p += R) if (p <= n) e_pulse[p] = oh;
            m = 1;
            while (m <= D && !sbit(e + m, idx)) m++;
            if (m <= D) h = e + m;
            else done = 1'b1;
          end
          for (int i = g; i < e + D && i <= n; i++) begin
            e_busy[i] = 1'b1;
            e_idx[i]  = 3'(idx);
            if (i >= lvl_from) e_level[i] = oh;
          end
          t = e + D + 1;
        end
        ptr = (idx + 1) % NB;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset   = 1'b1;
    btn_raw = '1;
    #1;
    checks++;
    if ({btn_pulse, btn_level, busy, active_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pulse=%b level=%b busy=%b idx=%0d, required all 0", btn_pulse, btn_level, busy, active_idx);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_busy: got %b, required 0", busy); end
    checks++;
    if (btn_pulse !== '0) begin errors++; $display("FAIL reset_held_pulse: got %b, required 0000", btn_pulse); end
    reset   = 1'b0;
    btn_raw = '0;
  endtask

  task automatic test_single_press();
    clear_trace();
    set_range(1, 40, 4'b0010);
    run_trace(60);
    checks++;
    if (first_pulse(1, 60) !== 11) begin errors++; $display("FAIL single_pulse_cycle: got %0d, required 11", first_pulse(1, 60)); end
    checks++;
    if (o_pulse[11] !== 4'b0010) begin errors++; $display("FAIL single_pulse_value: got %b, required 0010", o_pulse[11]); end
    checks++;
    if (count_pulses(1, 60) !== (REP ? 2 : 1)) begin errors++; $display("FAIL single_pulse_count: got %0d, required %0d", count_pulses(1, 60), REP ? 2 : 1); end
    checks++;
    if (o_busy[2] !== 1'b0) begin errors++; $display("FAIL single_busy_before_grant: got %b, required 0", o_busy[2]); end
    checks++;
    if ({o_busy[3], o_idx[3]} !== {1'b1, 3'd1}) begin errors++; $display("FAIL single_grant: got busy=%b idx=%0d, required busy=1 idx=1", o_busy[3], o_idx[3]); end
    checks++;
    if (o_level[10] !== 4'b0000) begin errors++; $display("FAIL single_level_settling: got %b, required 0000", o_level[10]); end
    checks++;
    if (o_level[50] !== 4'b0010) begin errors++; $display("FAIL single_level_release_settling: got %b, required 0010", o_level[50]); end
    checks++;
    if ({o_level[51], o_busy[51]} !== 5'b0) begin errors++; $display("FAIL single_released: got level=%b busy=%b, required 0000/0", o_level[51], o_busy[51]); end
  endtask

  task automatic test_reject();
    clear_trace();
    set_range(1, 5, 4'b0001);
    set_range(20, 70, 4'b1001);
    run_trace(90);
    checks++;
    if (count_pulses(1, 19) !== 0) begin errors++; $display("FAIL reject_no_pulse: got %0d pulses, required 0", count_pulses(1, 19)); end
    checks++;
    if ({o_busy[7], o_busy[8]} !== 2'b10) begin errors++; $display("FAIL reject_busy_drop: got %b%b, required 10", o_busy[7], o_busy[8]); end
    checks++;
    if (first_pulse(20, 90) !== 30) begin errors++; $display("FAIL reject_next_pulse_cycle: got %0d, required 30", first_pulse(20, 90)); end
    checks++;
    if ({o_pulse[30], o_idx[30]} !== {4'b1000, 3'd3}) begin errors++; $display("FAIL reject_rr_advanced: got pulse=%b idx=%0d, required 1000 idx=3", o_pulse[30], o_idx[30]); end
  endtask

  task automatic test_simultaneous();
    clear_trace();
    set_range(1, 20, 4'b1001);
    set_range(21, 70, 4'b1000);
    run_trace(90);
    checks++;
    if (o_pulse[11] !== 4'b0001) begin errors++; $display("FAIL simul_first: got %b, required 0001", o_pulse[11]); end
    checks++;
    if (count_pulses(12, 39) !== 0) begin errors++; $display("FAIL simul_waiting_quiet: got %0d pulses, required 0", count_pulses(12, 39)); end
    checks++;
    if (o_pulse[40] !== 4'b1000) begin errors++; $display("FAIL simul_second: got %b, required 1000", o_pulse[40]); end
    checks++;
    if (multi_pulses(1, 90) !== 0) begin errors++; $display("FAIL simul_multi_hot: got %0d cycles, required 0", multi_pulses(1, 90)); end
    checks++;
    if ({o_level[30], o_busy[31]} !== 5'b00010) begin errors++; $display("FAIL simul_handover: got level=%b busy=%b, required 0001/0", o_level[30], o_busy[31]); end
    checks++;
    if ({o_busy[35], o_idx[35]} !== {1'b1, 3'd3}) begin errors++; $display("FAIL simul_second_grant: got busy=%b idx=%0d, required 1/3", o_busy[35], o_idx[35]); end
  endtask

  task automatic test_release_bounce();
    clear_trace();
    set_range(1, 30, 4'b0100);
    set_range(34, 60, 4'b0100);
    run_trace(80);
    checks++;
    if (count_pulses(12, 80) !== (REP ? 2 : 0)) begin errors++; $display("FAIL bounce_extra_pulses: got %0d, required %0d", count_pulses(12, 80), REP ? 2 : 0); end
    checks++;
    if ({o_level[34], o_level[36]} !== {4'b0100, 4'b0100}) begin errors++; $display("FAIL bounce_level: got %b %b, required 0100 0100", o_level[34], o_level[36]); end
    checks++;
    if (o_level[70] !== 4'b0100) begin errors++; $display("FAIL bounce_final_settling: got %b, required 0100", o_level[70]); end
    checks++;
    if ({o_level[71], o_busy[71]} !== 5'b0) begin errors++; $display("FAIL bounce_final_release: got level=%b busy=%b, required 0000/0", o_level[71], o_busy[71]); end
  endtask

  task automatic test_reset_mid();
    clear_trace();
    set_range(1, 8, 4'b0001);
    run_trace(8);
    checks++;
    if (o_busy[8] !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b, required 1", o_busy[8]); end
    reset = 1'b1;
    #1;
    checks++;
    if ({btn_pulse, btn_level, busy, active_idx} !== '0) begin
      errors++;
      $display("FAIL midreset_async_clear: got pulse=%b level=%b busy=%b idx=%0d, required all 0", btn_pulse, btn_level, busy, active_idx);
    end
    clear_trace();
    set_range(1, 30, 4'b0001);
    run_trace(50);
    checks++;
    if (first_pulse(1, 50) !== 11) begin errors++; $display("FAIL midreset_fresh_press: got %0d, required 11", first_pulse(1, 50)); end
    checks++;
    if (count_pulses(1, 50) !== (REP ? 2 : 1)) begin errors++; $display("FAIL midreset_pulse_count: got %0d, required %0d", count_pulses(1, 50), REP ? 2 : 1); end
  endtask

  task automatic test_auto_repeat();
    clear_trace();
    set_range(1, 60, 4'b0100);
    run_trace(80);
    checks++;
    if (count_pulses(1, 80) !== (REP ? 4 : 1)) begin errors++; $display("FAIL repeat_count: got %0d, required %0d", count_pulses(1, 80), REP ? 4 : 1); end
    checks++;
    if (o_pulse[59] !== (REP ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL repeat_last: got %b, required %b", o_pulse[59], REP ? 4'b0100 : 4'b0000); end
  endtask

  task automatic test_random();
    for (int sd = 0; sd < 3; sd++) begin
      int n;
      n = 560;
      clear_trace();
      for (int b = 0; b < NB; b++) begin
        bit cur;
        int left;
        cur  = 1'b0;
        left = int'($urandom_range(1, 40));
        for (int i = 1; i <= n - 40; i++) begin
          if (left == 0) begin
            cur  = !cur;
            left = cur ? int'($urandom_range(1, 3 * D)) : int'($urandom_range(1, 50));
          end
          raw_tr[i][b] = cur;
          left--;
        end
      end
      run_trace(n);
      build_model(n);
      for (int i = 1; i <= n; i++) begin
        logic [11:0] got, want;
        got  = {o_pulse[i], o_level[i], o_busy[i], e_busy[i] ? o_idx[i] : 3'd0};
        want = {e_pulse[i], e_level[i], e_busy[i], e_busy[i] ? e_idx[i] : 3'd0};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random trace %0d cycle %0d: got pulse=%b level=%b busy=%b idx=%0d, required pulse=%b level=%b busy=%b idx=%0d",
                   sd, i, o_pulse[i], o_level[i], o_busy[i], o_idx[i], e_pulse[i], e_level[i], e_busy[i], e_idx[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_reject();
    test_simultaneous();
    test_release_bounce();
    test_reset_mid();
    test_auto_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, required completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
